// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default datapath width and the
// output-stage state type used by the registered logic unit.
package alu_pkg;

    localparam int OP_W          = 3;
    localparam int DEFAULT_WIDTH = 4;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result stream bundle of the logic unit; the DUT side takes the
// slave modport, the producer/consumer side takes the master modport.
interface logic_unit_pipe_if import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic            in_valid;
    logic            in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0] op;
    logic            use_acc;
    logic            out_valid;
    logic            out_ready;
    logic [WIDTH-1:0] y;
    logic            zero;
    logic            parity;

    modport slave (
        input  in_valid, a, b, op, use_acc, out_ready,
        output in_ready, out_valid, y, zero, parity
    );

    modport master (
        output in_valid, a, b, op, use_acc, out_ready,
        input  in_ready, out_valid, y, zero, parity
    );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation slice with zero/parity flags; a disabled
// unit produces an all-zero result so the flags follow automatically.
module logic_unit_core import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bx,
    input  logic [OP_W-1:0]  op,
    input  logic             enable,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    logic [WIDTH-1:0] raw;

    always_comb begin
        raw = '0;
        case (op)
            OP_AND:   raw = a & bx;
            OP_OR:    raw = a | bx;
            OP_XOR:   raw = a ^ bx;
            OP_NOR:   raw = ~(a | bx);
            OP_NAND:  raw = ~(a & bx);
            OP_XNOR:  raw = ~(a ^ bx);
            OP_NOTA:  raw = ~a;
            OP_PASSB: raw = bx;
            default:  raw = '0;
        endcase
    end

    assign result = enable ? raw : '0;
    assign zero   = (result == '0);
    assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: one-deep valid/ready output stage around
// logic_unit_core, plus an optional accumulator for chained reductions.
module logic_unit_pipe import alu_pkg::*; #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit ACC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              acc_clr,
    logic_unit_pipe_if.slave  bus,
    output logic [WIDTH-1:0]  acc_q
);

    out_state_e       state;
    out_state_e       next_state;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             core_parity;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             parity_q;

    assign in_ready = (state == OUT_EMPTY) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign bx       = (ACC_EN && bus.use_acc) ? acc_r : bus.b;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (bus.a),
        .bx     (bx),
        .op     (bus.op),
        .enable (enable),
        .result (core_y),
        .zero   (core_zero),
        .parity (core_parity)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OUT_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // A simultaneous drain and accept keeps the stage full for 1 beat/cycle.
    always_comb begin
        next_state = state;
        case (state)
            OUT_EMPTY: if (accept) next_state = OUT_FULL;
            OUT_FULL:  if (bus.out_ready && !accept) next_state = OUT_EMPTY;
            default:   next_state = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else if (accept) begin
            y_q      <= core_y;
            zero_q   <= core_zero;
            parity_q <= core_parity;
        end
    end

    // Clear wins over an update; the accepted beat has already used the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (ACC_EN) begin
            if (acc_clr) begin
                acc_r <= '0;
            end else if (accept && enable && bus.use_acc) begin
                acc_r <= core_y;
            end
        end
    end

    assign acc_q         = ACC_EN ? acc_r : '0;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == OUT_FULL);
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised bench for logic_unit_pipe: a 4-bit accumulating instance and an
// 8-bit instance without accumulator, both checked against a truth-table model.
module tb_logic_unit_pipe;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       acc_clr;
    logic [3:0] acc4;
    logic [7:0] acc8;

    int tests;
    int fails;

    logic [7:0] q4[$];
    logic [7:0] q8[$];
    logic [7:0] macc4;

    logic_unit_pipe_if #(.WIDTH(4)) bus4 ();
    logic_unit_pipe_if #(.WIDTH(8)) bus8 ();

    logic_unit_pipe #(.WIDTH(4), .ACC_EN(1'b1)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .acc_clr (acc_clr),
        .bus     (bus4),
        .acc_q   (acc4)
    );

    logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b0)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .acc_clr (acc_clr),
        .bus     (bus8),
        .acc_q   (acc8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each op is described by its per-bit truth table indexed by {a_i, bx_i}.
    function automatic logic [7:0] refOp(input logic [2:0] op_sel, input logic [7:0] x,
                                         input logic [7:0] z, input int w);
        logic [3:0] tt;
        logic [7:0] r;
        r = '0;
        case (op_sel)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1010;
        endcase
        for (int i = 0; i < w; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    task automatic checkPipe(input bit sel8);
        int         qs;
        logic [7:0] e;
        qs = sel8 ? q8.size() : q4.size();
        checkOutput(sel8 ? "out_valid8" : "out_valid4",
                    sel8 ? bus8.out_valid : bus4.out_valid, qs != 0);
        if (qs != 0) begin
            e = sel8 ? q8[0] : q4[0];
            checkOutput(sel8 ? "y8" : "y4", sel8 ? bus8.y : {4'h0, bus4.y}, e);
            checkOutput(sel8 ? "zero8" : "zero4", sel8 ? bus8.zero : bus4.zero, e == 8'h00);
            checkOutput(sel8 ? "parity8" : "parity4", sel8 ? bus8.parity : bus4.parity, ^e);
        end
        if (sel8) checkOutput("acc8", acc8, 0);
        else      checkOutput("acc4", acc4, macc4);
    endtask

    task automatic checkReset();
        checkOutput("rst_valid4", bus4.out_valid, 0);
        checkOutput("rst_y4", bus4.y, 0);
        checkOutput("rst_zero4", bus4.zero, 1);
        checkOutput("rst_parity4", bus4.parity, 0);
        checkOutput("rst_acc4", acc4, 0);
        checkOutput("rst_valid8", bus8.out_valid, 0);
        checkOutput("rst_y8", bus8.y, 0);
        checkOutput("rst_zero8", bus8.zero, 1);
        q4.delete();
        q8.delete();
        macc4 = '0;
    endtask

    // Drive one cycle on the selected instance, update the model, check after the edge.
    task automatic applyStimulus(input bit sel8, input logic iv, input logic [7:0] av,
                                 input logic [7:0] bv, input logic [2:0] opv, input logic ua,
                                 input logic en, input logic clr, input logic ordy);
        int         qs;
        bit         rdy_exp;
        bit         take;
        logic [7:0] bx;
        logic [7:0] r;
        enable  = en;
        acc_clr = clr;
        if (sel8) begin
            bus8.in_valid = iv;  bus8.a = av;  bus8.b = bv;  bus8.op = opv;
            bus8.use_acc = ua;   bus8.out_ready = ordy;
            bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
        end else begin
            bus4.in_valid = iv;  bus4.a = av[3:0];  bus4.b = bv[3:0];  bus4.op = opv;
            bus4.use_acc = ua;   bus4.out_ready = ordy;
            bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        end
        #1;
        qs      = sel8 ? q8.size() : q4.size();
        rdy_exp = (qs == 0) || ordy;
        checkOutput(sel8 ? "in_ready8" : "in_ready4",
                    sel8 ? bus8.in_ready : bus4.in_ready, rdy_exp);
        bx   = (!sel8 && ua) ? macc4 : bv;
        r    = en ? refOp(opv, av, bx, sel8 ? 8 : 4) : 8'h00;
        take = iv && rdy_exp;
        if (sel8) begin
            if (qs != 0 && ordy) void'(q8.pop_front());
            if (take) q8.push_back(r);
        end else begin
            if (qs != 0 && ordy) void'(q4.pop_front());
            if (take) q4.push_back(r);
            if (clr) macc4 = '0;
            else if (take && en && ua) macc4 = r;
        end
        @(posedge clk);
        #1;
        checkPipe(sel8);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] ra, rb, bb_a, bb_b;
        logic [2:0] rop;
        tests = 0;
        fails = 0;
        macc4 = '0;
        rst_n = 1'b0;
        enable = 1'b0;
        acc_clr = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.op = '0;
        bus4.use_acc = 1'b0;  bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0;
        bus8.use_acc = 1'b0;  bus8.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkReset();
        rst_n = 1'b1;

        applyStimulus(0, 1, 8'h0A, 8'h06, OP_OR, 0, 1, 0, 1);
        checkOutput("single_or_y", bus4.y, 4'b1110);
        checkOutput("single_or_parity", bus4.parity, 1);
        applyStimulus(0, 1, 8'h0A, 8'h06, OP_XOR, 0, 1, 0, 1);
        checkOutput("single_xor_y", bus4.y, 4'b1100);
        checkOutput("single_xor_parity", bus4.parity, 0);

        applyStimulus(0, 0, 8'h00, 8'h00, OP_AND, 0, 1, 1, 1);
        applyStimulus(0, 1, 8'h01, 8'h00, OP_OR, 1, 1, 0, 1);
        checkOutput("chain_y1", bus4.y, 4'b0001);
        applyStimulus(0, 1, 8'h04, 8'h00, OP_OR, 1, 1, 0, 1);
        checkOutput("chain_y2", bus4.y, 4'b0101);
        applyStimulus(0, 1, 8'h08, 8'h00, OP_OR, 1, 1, 0, 1);
        checkOutput("chain_y3", bus4.y, 4'b1101);
        checkOutput("chain_acc", acc4, 4'b1101);
        applyStimulus(0, 1, 8'h0F, 8'h00, OP_OR, 1, 0, 0, 1);
        checkOutput("gate_y", bus4.y, 4'b0000);
        checkOutput("gate_zero", bus4.zero, 1);
        checkOutput("gate_acc", acc4, 4'b1101);
        applyStimulus(0, 1, 8'h02, 8'h00, OP_OR, 1, 1, 1, 1);
        checkOutput("clr_beat_y", bus4.y, 4'b1111);
        checkOutput("clr_beat_acc", acc4, 4'b0000);

        applyStimulus(0, 0, 8'h00, 8'h00, OP_AND, 0, 1, 0, 1);
        ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
        applyStimulus(0, 1, ra, rb, rop, 0, 1, 0, 0);
        bb_a = 8'($urandom); bb_b = 8'($urandom);
        repeat (3) applyStimulus(0, 1, bb_a, bb_b, OP_XNOR, 0, 1, 0, 0);
        applyStimulus(0, 1, bb_a, bb_b, OP_XNOR, 0, 1, 0, 1);
        applyStimulus(0, 1, 8'h05, 8'h0C, OP_NAND, 0, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 8'h00, OP_AND, 0, 1, 0, 1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'($urandom), 8'($urandom), 3'($urandom),
                          1'($urandom), 1, 0, 1);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, OP_AND, 0, 1, 0, 1);

        applyStimulus(0, 1, 8'h06, 8'h0B, OP_OR, 1, 1, 0, 1);
        applyStimulus(0, 1, 8'h03, 8'h05, OP_AND, 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 8'h09, 8'h03, OP_NOR, 0, 1, 0, 1);
        checkOutput("post_rst_y", bus4.y, 4'b0100);

        applyStimulus(1, 1, 8'h3C, 8'hA5, OP_PASSB, 1, 1, 0, 1);
        checkOutput("noacc_pass_y", bus8.y, 8'hA5);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1, 8'($urandom), 8'($urandom), 3'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        applyStimulus(1, 0, 8'h00, 8'h00, OP_AND, 0, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
